// File: rtl/hazard_scoreboard_ctrl_if.sv
// Decode-side hazard bus between the ID stage and the hazard controller.
// The ID stage is the master (drives decode fields and redirects); the
// hazard controller is the slave (returns stall/flush controls and counters).
interface hazard_scoreboard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 16
);
  logic [1:0]        branch_ctrl;
  logic              dec_valid;
  logic [REG_AW-1:0] dec_rs1_addr;
  logic [REG_AW-1:0] dec_rs2_addr;
  logic              dec_rs1_en;
  logic              dec_rs2_en;
  logic [REG_AW-1:0] dec_rd_addr;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_muldiv;

  logic              pc_write;
  logic              ifid_write;
  logic              instr_flush;
  logic              id_flush;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_events;

  modport master (
    output branch_ctrl, dec_valid, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_en, dec_rs2_en, dec_rd_addr, dec_reg_write,
           dec_mem_read, dec_muldiv,
    input  pc_write, ifid_write, instr_flush, id_flush,
           stall_cycles, flush_events
  );

  modport slave (
    input  branch_ctrl, dec_valid, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_en, dec_rs2_en, dec_rd_addr, dec_reg_write,
           dec_mem_read, dec_muldiv,
    output pc_write, ifid_write, instr_flush, id_flush,
           stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// Pipeline hazard controller for the in-order RV32 core.
// Tracks per-register result latency, mul/div unit occupancy and the
// fetch-side flush shadow after a redirect, and drives PC / IF/ID / ID/EX
// stall and flush controls combinationally from that state.
// Saturating counters record stall cycles and redirect events.
module hazard_scoreboard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int MULDIV_LAT  = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int PERF_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  hazard_scoreboard_ctrl_if.slave   bus
);

  localparam int NUM_REGS = 2 ** REG_AW;
  localparam int MAX_LAT  = (LOAD_LAT > MULDIV_LAT) ? LOAD_LAT : MULDIV_LAT;
  localparam int CW       = $clog2(MAX_LAT + 1);
  // A single-cycle flush needs no shadow, but keep a 1-bit register so the
  // logic stays uniform; it is simply never loaded with a nonzero value.
  localparam int FW       = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  localparam logic [CW-1:0] LOAD_V   = CW'(LOAD_LAT);
  localparam logic [CW-1:0] MULDIV_V = CW'(MULDIV_LAT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [FW-1:0] FL_LOAD  = FW'(FLUSH_DEPTH - 1);
  localparam logic [FW-1:0] FL_ONE   = FW'(1);

  // Remaining cycles until each register's pending result can be read.
  logic [CW-1:0]     cnt [NUM_REGS];
  logic [CW-1:0]     md_busy;
  logic [FW-1:0]     fl_cnt;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  logic          redirect;
  logic          shadow;
  logic          rs1_busy;
  logic          rs2_busy;
  logic          raw_haz;
  logic          struct_haz;
  logic          stall;
  logic          stall_out;
  logic          issue;
  logic [CW-1:0] rd_lat;

  // Hazard detection from scoreboard state and the instruction sitting in ID.
  always_comb begin
    redirect   = (bus.branch_ctrl != 2'b00);
    shadow     = (fl_cnt != '0);
    rs1_busy   = bus.dec_rs1_en && (bus.dec_rs1_addr != '0) &&
                 (cnt[bus.dec_rs1_addr] != '0);
    rs2_busy   = bus.dec_rs2_en && (bus.dec_rs2_addr != '0) &&
                 (cnt[bus.dec_rs2_addr] != '0);
    raw_haz    = bus.dec_valid && (rs1_busy || rs2_busy);
    struct_haz = bus.dec_valid && bus.dec_muldiv && (md_busy != '0);
    stall      = raw_haz || struct_haz;
    // A stall only reaches the outputs when neither redirect nor shadow owns them.
    stall_out  = !redirect && !shadow && stall;
    issue      = bus.dec_valid && !redirect && !shadow && !stall;
  end

  // Latency the issuing instruction's rd will be unavailable for.
  always_comb begin
    rd_lat = '0;
    if (bus.dec_mem_read) begin
      rd_lat = LOAD_V;
    end else if (bus.dec_muldiv) begin
      rd_lat = MULDIV_V;
    end
  end

  // Output priority: redirect, flush shadow, stall, normal.
  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.instr_flush = 1'b0;
    bus.id_flush    = 1'b0;
    if (redirect) begin
      bus.instr_flush = 1'b1;
      bus.id_flush    = 1'b1;
    end else if (shadow) begin
      bus.instr_flush = 1'b1;
    end else if (stall) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.id_flush    = 1'b1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_events = flush_cnt;

  // Per-register scoreboard: issue loads the latency, otherwise count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      // x0 is hardwired zero and never becomes a hazard source.
      cnt[0] <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (issue && bus.dec_reg_write && (bus.dec_rd_addr == REG_AW'(r))) begin
          cnt[r] <= rd_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - CNT_ONE;
        end
      end
    end
  end

  // Mul/div occupancy: the unit is unpipelined, so a new op waits for zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_busy <= '0;
    end else if (issue && bus.dec_muldiv) begin
      md_busy <= MULDIV_V;
    end else if (md_busy != '0) begin
      md_busy <= md_busy - CNT_ONE;
    end
  end

  // Flush shadow: extra fetch-side flush cycles after each redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fl_cnt <= '0;
    end else if (redirect) begin
      fl_cnt <= FL_LOAD;
    end else if (fl_cnt != '0) begin
      fl_cnt <= fl_cnt - FL_ONE;
    end
  end

  // Saturating stall-cycle counter, counting only cycles the stall drives outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_out && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

  // Saturating redirect counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
    end else if (redirect && (flush_cnt != '1)) begin
      flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end

endmodule
